alu_seq_core: RTL and testbench

- Parametrised successor to the team's single-cycle ALU.
- Operates on WIDTH-bit operands with full valid/ready handshakes on both input and output, so back-pressure is supported.
- DIV/REM use an iterative restoring divider (WIDTH cycles); all other ops complete in 1 cycle.
- Sits between the operand-fetch stage and the writeback stage; holds one operation in flight.

---
 rtl/alu_seq_pkg.sv | 18 +
 rtl/alu_seq_divider.sv | 53 +++++
 rtl/alu_seq_core.sv | 112 +++++++++++
 tb/tb_alu_seq_core.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcode and FSM state types shared by the sequential ALU core and its divider
package alu_seq_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_REM = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_XOR = 3'b111
  } op_e;
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_e;
  function automatic logic is_div_op(op_e op);
    return op == OP_DIV || op == OP_REM;
  endfunction
endpackage

// File: rtl/alu_seq_divider.sv
// alu_seq_divider: iterative restoring unsigned divider, one quotient bit per cycle, MSB first
module alu_seq_divider
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div0
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   r_sub;
  assign div0 = divisor == '0;
  assign done = busy && cnt == '0;
  // Shift the next dividend bit into the partial remainder and trial-subtract the divisor
  always_comb begin
    r_sh  = {remainder, quotient[WIDTH-1]};
    r_sub = r_sh - {1'b0, d};
  end
  // Quotient register doubles as the dividend shift register; a negative trial keeps the old remainder
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      cnt       <= '0;
      d         <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt       <= CNT_W'(WIDTH);
      d         <= divisor;
      quotient  <= dividend;
      remainder <= '0;
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else begin
        cnt <= cnt - 1'b1;
        {remainder, quotient} <= r_sub[WIDTH] ? {r_sh[WIDTH-1:0], quotient[WIDTH-2:0], 1'b0}
                                              : {r_sub[WIDTH-1:0], quotient[WIDTH-2:0], 1'b1};
      end
    end
  end
endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: handshaked WIDTH-bit ALU, single-cycle ops plus iterative DIV/REM; ALU_SEQ_FLAGS_EN adds zero_o/carry_o
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [2:0]       operation,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result,
  output logic             err_o
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero_o,
  output logic             carry_o
`endif
);
  state_e           state, state_n;
  op_e              op, op_q;
  logic             accept, is_div, div_start, div_busy, div_done, div0;
  logic [WIDTH-1:0] alu_res, quot, rem, div_res;
  assign op        = op_e'(operation);
  assign is_div    = is_div_op(op);
  assign div_start = accept && is_div && !div0;
  assign valid_o   = state == DONE;
  assign div_res   = op_q == OP_DIV ? quot : rem;
  alu_seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (div_start),
    .dividend  (operand_a),
    .divisor   (operand_b),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quot),
    .remainder (rem),
    .div0      (div0)
  );
  // Single-cycle result; DIV/REM entries only matter for divide-by-zero, which never enters the divider
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = operand_a + operand_b;
      OP_SUB: alu_res = operand_a - operand_b;
      OP_MUL: alu_res = operand_a * operand_b;
      OP_DIV: alu_res = '1;
      OP_REM: alu_res = operand_a;
      OP_AND: alu_res = operand_a & operand_b;
      OP_OR:  alu_res = operand_a | operand_b;
      OP_XOR: alu_res = operand_a ^ operand_b;
      default: alu_res = '0;
    endcase
  end
`ifdef ALU_SEQ_FLAGS_EN
  logic [WIDTH:0] add_x;
  logic           alu_carry;
  // Carry-out of ADD, borrow of SUB, zero otherwise
  always_comb begin
    add_x     = {1'b0, operand_a} + {1'b0, operand_b};
    alu_carry = op == OP_ADD ? add_x[WIDTH] : op == OP_SUB ? operand_a < operand_b : 1'b0;
  end
`endif
  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else state <= state_n;
  end
  // Handshake and next state; a retiring DONE may accept the next op in the same cycle
  always_comb begin
    ready_o = state == IDLE || (state == DONE && ready_i);
    accept  = valid_i && ready_o;
    state_n = state;
    if (accept) state_n = div_start ? DIV : DONE;
    else if (state == DIV) state_n = div_done ? DONE : div_busy ? DIV : IDLE;
    else if (state == DONE && ready_i) state_n = IDLE;
  end
  // Result registers load on a single-cycle accept or when the divider finishes, held otherwise
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_q   <= OP_ADD;
      result <= '0;
      err_o  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_o  <= 1'b0;
      carry_o <= 1'b0;
`endif
    end else if (accept) begin
      op_q <= op;
      if (!div_start) begin
        result <= alu_res;
        err_o  <= is_div;
`ifdef ALU_SEQ_FLAGS_EN
        zero_o  <= alu_res == '0;
        carry_o <= alu_carry;
`endif
      end
    end else if (state == DIV && div_done) begin
      result <= div_res;
      err_o  <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero_o  <= div_res == '0;
      carry_o <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: table-driven and directed checks for alu_seq_core (WIDTH=32); ALU_SEQ_FLAGS_EN also checks flags
module tb_alu_seq_core;
  import alu_seq_pkg::*;
  logic        clk = 0, rst_i = 1, valid_i = 0, ready_i = 1;
  logic        ready_o, valid_o, err_o;
  logic [31:0] operand_a = 0, operand_b = 0, result;
  logic [2:0]  operation = 0;
`ifdef ALU_SEQ_FLAGS_EN
  logic        zero_o, carry_o;
`endif
  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, res;
    logic        err, zero, carry;
  } vec_t;
  vec_t vecs[18];

  alu_seq_core #(.WIDTH(32)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .operation (operation),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .result    (result),
    .err_o     (err_o)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .zero_o    (zero_o),
    .carry_o   (carry_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op with ready_i=1, wait for its result and compare it
  task automatic run_op(input string name, input vec_t v);
    int n;
    operation = v.op; operand_a = v.a; operand_b = v.b; valid_i = 1; ready_i = 1;
    n = 0;
    while (!ready_o && n < 100) begin tick(); n++; end
    tick();
    valid_i = 0;
    n = 0;
    while (!valid_o && n < 100) begin tick(); n++; end
    chk({name, " valid"}, 32'(valid_o), 32'd1);
    chk({name, " result"}, result, v.res);
    chk({name, " err"}, 32'(err_o), 32'(v.err));
`ifdef ALU_SEQ_FLAGS_EN
    chk({name, " zero"}, 32'(zero_o), 32'(v.zero));
    chk({name, " carry"}, 32'(carry_o), 32'(v.carry));
`endif
    tick();
  endtask

  initial begin
    int n, bad_ready;
    vecs[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'd1,        32'h00000000, 0, 1, 1};
    vecs[1]  = '{OP_ADD, 32'd2,        32'd3,        32'd5,        0, 0, 0};
    vecs[2]  = '{OP_SUB, 32'd3,        32'd5,        32'hFFFFFFFE, 0, 0, 1};
    vecs[3]  = '{OP_SUB, 32'd9,        32'd4,        32'd5,        0, 0, 0};
    vecs[4]  = '{OP_MUL, 32'h10000,    32'h10000,    32'h00000000, 0, 1, 0};
    vecs[5]  = '{OP_MUL, 32'd1234,     32'd5678,     32'd7006652,  0, 0, 0};
    vecs[6]  = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        0, 0, 0};
    vecs[7]  = '{OP_DIV, 32'd100,      32'd7,        32'd14,       0, 0, 0};
    vecs[8]  = '{OP_REM, 32'd100,      32'd7,        32'd2,        0, 0, 0};
    vecs[9]  = '{OP_DIV, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 0};
    vecs[10] = '{OP_REM, 32'd5,        32'd0,        32'd5,        1, 0, 0};
    vecs[11] = '{OP_DIV, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 0, 0, 0};
    vecs[12] = '{OP_REM, 32'hFFFFFFFF, 32'h10,       32'hF,        0, 0, 0};
    vecs[13] = '{OP_DIV, 32'd7,        32'd100,      32'd0,        0, 1, 0};
    vecs[14] = '{OP_REM, 32'h80000000, 32'd3,        32'd2,        0, 0, 0};
    vecs[15] = '{OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 0, 0, 0};
    vecs[16] = '{OP_OR,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 0, 0, 0};
    vecs[17] = '{OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 0, 0};

    // Reset state
    #12;
    chk("rst valid_o", 32'(valid_o), 32'd0);
    chk("rst result", result, 32'd0);
    chk("rst err_o", 32'(err_o), 32'd0);
    chk("rst ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_i = 0;
    tick();

    for (int i = 0; i < 18; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // DIV latency: ready_o low while dividing, valid_o 33 edges after accept
    operation = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; valid_i = 1;
    tick();
    valid_i = 0; operand_a = 32'd1; operand_b = 32'd1;
    n = 0; bad_ready = 0;
    while (!valid_o && n < 60) begin
      if (ready_o) bad_ready++;
      tick();
      n++;
    end
    chk("div latency", 32'(n), 32'd33);
    chk("div ready_o low", 32'(bad_ready), 32'd0);
    chk("div result", result, 32'd14);
    tick();

    // Back-pressure: result held, second op held off until retire
    ready_i = 0;
    operation = OP_XOR; operand_a = 32'hF0F0F0F0; operand_b = 32'h0FF00FF0; valid_i = 1;
    tick();
    operation = OP_ADD; operand_a = 32'd2; operand_b = 32'd3;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp valid %0d", k), 32'(valid_o), 32'd1);
      chk($sformatf("bp result %0d", k), result, 32'hFF00FF00);
      chk($sformatf("bp ready_o %0d", k), 32'(ready_o), 32'd0);
    end
    ready_i = 1;
    #1;
    chk("bp ready_o release", 32'(ready_o), 32'd1);
    tick();
    valid_i = 0;
    chk("bp second valid", 32'(valid_o), 32'd1);
    chk("bp second result", result, 32'd5);
    tick();
    chk("bp drained", 32'(valid_o), 32'd0);

    // Streaming single-cycle ops, one result per cycle
    begin
      logic [2:0]  s_op[4]  = '{OP_SUB, OP_MUL, OP_AND, OP_OR};
      logic [31:0] s_a[4]   = '{32'd3, 32'h10000, 32'hFF00FF00, 32'h12340000};
      logic [31:0] s_b[4]   = '{32'd5, 32'h10000, 32'h0F0F0F0F, 32'h00005678};
      logic [31:0] s_exp[4] = '{32'hFFFFFFFE, 32'h0, 32'h0F000F00, 32'h12345678};
      for (int k = 0; k < 4; k++) begin
        operation = s_op[k]; operand_a = s_a[k]; operand_b = s_b[k]; valid_i = 1;
        tick();
        chk($sformatf("stream valid %0d", k), 32'(valid_o), 32'd1);
        chk($sformatf("stream result %0d", k), result, s_exp[k]);
      end
      valid_i = 0;
      tick();
      chk("stream drained", 32'(valid_o), 32'd0);
    end

    // Asynchronous reset mid-division aborts it
    operation = OP_DIV; operand_a = 32'd100; operand_b = 32'd7; valid_i = 1;
    tick();
    valid_i = 0;
    repeat (10) tick();
    #2 rst_i = 1;
    #1;
    chk("midrst valid_o", 32'(valid_o), 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst ready_o", 32'(ready_o), 32'd1);
    @(negedge clk);
    rst_i = 0;
    tick();
    chk("postrst ready_o", 32'(ready_o), 32'd1);
    n = 0;
    repeat (35) begin tick(); if (valid_o) n++; end
    chk("postrst no result", 32'(n), 32'd0);
    run_op("postrst add", vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
